// File: rtl/pe_pkg.sv
// Shared types and clamp limits for the double-buffered-weight MAC processing element.
// The stage-1 record is sized to the widest supported accumulator; instances use its low bits.
package pe_pkg;

  localparam int PE_MAX_W = 64;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic                vld;
    logic [PE_MAX_W-1:0] prod;
    logic [PE_MAX_W-1:0] psum;
  } stage1_t;

  function automatic logic [PE_MAX_W-1:0] acc_sat_max(input int aw, input int sgn);
    logic [PE_MAX_W-1:0] one;
    one = {{(PE_MAX_W-1){1'b0}}, 1'b1};
    if (sgn != 0)
      return (one << (aw - 1)) - one;
    else if (aw >= PE_MAX_W)
      return '1;
    else
      return (one << aw) - one;
  endfunction

  // Low aw bits of the signed result form the two's-complement minimum 100..0.
  function automatic logic [PE_MAX_W-1:0] acc_sat_min(input int aw, input int sgn);
    logic [PE_MAX_W-1:0] one;
    one = {{(PE_MAX_W-1){1'b0}}, 1'b1};
    if (sgn != 0)
      return ~((one << (aw - 1)) - one);
    else
      return '0;
  endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational extend + add + optional clamp of a product onto a partial sum.
// The sum is formed one bit wider than the accumulator, so it is always exact.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACCWIDTH  = 24,
  parameter int PRODWIDTH = 16,
  parameter int SIGNED    = 1,
  parameter int SATURATE  = 0
) (
  input  logic [PRODWIDTH-1:0] prod,
  input  logic [ACCWIDTH-1:0]  psum,
  output logic [ACCWIDTH-1:0]  sum,
  output logic                 ovf
);

  localparam logic [PE_MAX_W-1:0] SAT_MAX_W = acc_sat_max(ACCWIDTH, SIGNED);
  localparam logic [PE_MAX_W-1:0] SAT_MIN_W = acc_sat_min(ACCWIDTH, SIGNED);
  localparam logic [ACCWIDTH-1:0] SAT_MAX   = SAT_MAX_W[ACCWIDTH-1:0];
  localparam logic [ACCWIDTH-1:0] SAT_MIN   = SAT_MIN_W[ACCWIDTH-1:0];

  logic                       sx_prod;
  logic                       sx_psum;
  logic signed [ACCWIDTH:0]   prod_x;
  logic signed [ACCWIDTH:0]   psum_x;
  logic signed [ACCWIDTH:0]   sum_x;

  assign sx_prod = (SIGNED != 0) && prod[PRODWIDTH-1];
  assign sx_psum = (SIGNED != 0) && psum[ACCWIDTH-1];
  assign prod_x  = {{(ACCWIDTH+1-PRODWIDTH){sx_prod}}, prod};
  assign psum_x  = {sx_psum, psum};
  assign sum_x   = prod_x + psum_x;

  always_comb begin
    ovf = (SIGNED != 0) ? (sum_x[ACCWIDTH] ^ sum_x[ACCWIDTH-1]) : sum_x[ACCWIDTH];
    sum = sum_x[ACCWIDTH-1:0];
    if (ovf && (SATURATE != 0)) begin
      // Unsigned sums can only exceed the top, so only the signed case can clamp low.
      if ((SIGNED != 0) && sum_x[ACCWIDTH])
        sum = SAT_MIN;
      else
        sum = SAT_MAX;
    end
  end

endmodule

// File: rtl/pe_dbw_mac.sv
// Weight-stationary systolic MAC PE with shadow/active weight double buffer,
// optional multiply pipeline stage, wrap/saturate accumulation and sticky overflow.
module pe_dbw_mac
  import pe_pkg::*;
#(
  parameter int DATAWIDTH = 8,
  parameter int ACCWIDTH  = 3 * DATAWIDTH,
  parameter int SIGNED    = 1,
  parameter int PIPE_MUL  = 1,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wt_load,
  input  logic [DATAWIDTH-1:0] wt,
  input  logic                 wt_swap,
  output logic [DATAWIDTH-1:0] wt_out,
  output logic                 wt_load_out,
  input  logic                 valid_in,
  input  logic [DATAWIDTH-1:0] in_A,
  input  logic [ACCWIDTH-1:0]  in_B,
  output logic [DATAWIDTH-1:0] out_A,
  output logic                 valid_out,
  output logic [ACCWIDTH-1:0]  out_D,
  output logic                 ovf,
  input  logic                 clr_ovf
);

  localparam int PRODW = 2 * DATAWIDTH;

  wb_state_e            wb_state;
  logic [DATAWIDTH-1:0] active_w;
  logic [DATAWIDTH-1:0] shadow_w;
  logic                 do_swap;

  assign do_swap = wt_swap && (wb_state == WB_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_state <= WB_EMPTY;
      active_w <= '0;
      shadow_w <= '0;
    end else begin
      if (do_swap)
        active_w <= shadow_w;
      // A load in the swap cycle refills the shadow just vacated.
      if (wt_load) begin
        shadow_w <= wt;
        wb_state <= WB_FULL;
      end else if (do_swap) begin
        wb_state <= WB_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_out      <= '0;
      wt_load_out <= 1'b0;
      out_A       <= '0;
    end else begin
      wt_out      <= wt;
      wt_load_out <= wt_load;
      out_A       <= in_A;
    end
  end

  // Stage p0: multiply against the active weight as it stands this cycle.
  logic signed [PRODW-1:0] a_ext_p0;
  logic signed [PRODW-1:0] w_ext_p0;
  logic signed [PRODW-1:0] prod_p0;

  assign a_ext_p0 = {{DATAWIDTH{(SIGNED != 0) && in_A[DATAWIDTH-1]}}, in_A};
  assign w_ext_p0 = {{DATAWIDTH{(SIGNED != 0) && active_w[DATAWIDTH-1]}}, active_w};
  assign prod_p0  = a_ext_p0 * w_ext_p0;

  logic                vld_p1;
  logic [PRODW-1:0]    prod_p1;
  logic [ACCWIDTH-1:0] psum_p1;

  // Stage p1: optional product register.
  if (PIPE_MUL != 0) begin : g_pipe
    stage1_t s1_p1;
    logic    unused_s1_hi;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_p1 <= '0;
      end else begin
        s1_p1.vld <= valid_in;
        if (valid_in) begin
          s1_p1.prod <= {{(PE_MAX_W-PRODW){1'b0}}, prod_p0};
          s1_p1.psum <= {{(PE_MAX_W-ACCWIDTH){1'b0}}, in_B};
        end
      end
    end

    assign vld_p1       = s1_p1.vld;
    assign prod_p1      = s1_p1.prod[PRODW-1:0];
    assign psum_p1      = s1_p1.psum[ACCWIDTH-1:0];
    assign unused_s1_hi = ^{s1_p1.prod[PE_MAX_W-1:PRODW], s1_p1.psum[PE_MAX_W-1:ACCWIDTH]};
  end else begin : g_nopipe
    assign vld_p1  = valid_in;
    assign prod_p1 = prod_p0;
    assign psum_p1 = in_B;
  end

  logic [ACCWIDTH-1:0] sum_p1;
  logic                add_ovf_p1;

  pe_sat_add #(
    .ACCWIDTH (ACCWIDTH),
    .PRODWIDTH(PRODW),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .prod(prod_p1),
    .psum(psum_p1),
    .sum (sum_p1),
    .ovf (add_ovf_p1)
  );

  // Stage p2: output register; out_D holds between valid results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      out_D     <= '0;
      ovf       <= 1'b0;
    end else begin
      valid_out <= vld_p1;
      if (vld_p1)
        out_D <= sum_p1;
      if (vld_p1 && add_ovf_p1)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_dbw_mac.sv
// Directed bench for pe_dbw_mac: default build, a latency-1 build, and 16-bit
// accumulator builds in saturate and wrap modes, all fed from one control stream.
module tb_pe_dbw_mac;

  logic        clk;
  logic        rst_n;
  logic        wt_load;
  logic [7:0]  wt;
  logic        wt_swap;
  logic        valid_in;
  logic [7:0]  in_A;
  logic [23:0] in_B;
  logic [15:0] in_B16;
  logic        clr_ovf;

  logic [7:0]  wt_out, wt_out0, wt_out_s, wt_out_w;
  logic        wt_load_out, wt_load_out0, wt_load_out_s, wt_load_out_w;
  logic [7:0]  out_A, out_A0, out_A_s, out_A_w;
  logic        valid_out, valid_out0, valid_out_s, valid_out_w;
  logic [23:0] out_D, out_D0;
  logic [15:0] out_D_s, out_D_w;
  logic        ovf, ovf0, ovf_s, ovf_w;

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pe_dbw_mac #(.DATAWIDTH(8), .ACCWIDTH(24), .SIGNED(1), .PIPE_MUL(1), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .wt_load(wt_load), .wt(wt), .wt_swap(wt_swap),
    .wt_out(wt_out), .wt_load_out(wt_load_out), .valid_in(valid_in), .in_A(in_A),
    .in_B(in_B), .out_A(out_A), .valid_out(valid_out), .out_D(out_D), .ovf(ovf),
    .clr_ovf(clr_ovf));

  pe_dbw_mac #(.DATAWIDTH(8), .ACCWIDTH(24), .SIGNED(1), .PIPE_MUL(0), .SATURATE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wt_load(wt_load), .wt(wt), .wt_swap(wt_swap),
    .wt_out(wt_out0), .wt_load_out(wt_load_out0), .valid_in(valid_in), .in_A(in_A),
    .in_B(in_B), .out_A(out_A0), .valid_out(valid_out0), .out_D(out_D0), .ovf(ovf0),
    .clr_ovf(clr_ovf));

  pe_dbw_mac #(.DATAWIDTH(8), .ACCWIDTH(16), .SIGNED(1), .PIPE_MUL(1), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .wt_load(wt_load), .wt(wt), .wt_swap(wt_swap),
    .wt_out(wt_out_s), .wt_load_out(wt_load_out_s), .valid_in(valid_in), .in_A(in_A),
    .in_B(in_B16), .out_A(out_A_s), .valid_out(valid_out_s), .out_D(out_D_s), .ovf(ovf_s),
    .clr_ovf(clr_ovf));

  pe_dbw_mac #(.DATAWIDTH(8), .ACCWIDTH(16), .SIGNED(1), .PIPE_MUL(1), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .wt_load(wt_load), .wt(wt), .wt_swap(wt_swap),
    .wt_out(wt_out_w), .wt_load_out(wt_load_out_w), .valid_in(valid_in), .in_A(in_A),
    .in_B(in_B16), .out_A(out_A_w), .valid_out(valid_out_w), .out_D(out_D_w), .ovf(ovf_w),
    .clr_ovf(clr_ovf));

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    wt_load  = 1'b0;
    wt_swap  = 1'b0;
    valid_in = 1'b0;
    clr_ovf  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wt = '0; in_A = '0; in_B = '0; in_B16 = '0;
    idle();
    repeat (2) tick();
    check_eq("rst_valid_out", {31'd0, valid_out}, 32'd0);
    check_eq("rst_out_D", {8'd0, out_D}, 32'd0);
    check_eq("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    tick();

    // No weight loaded: product is zero, result is in_B.
    valid_in = 1'b1; in_A = 8'd5; in_B = 24'd7;
    tick();
    valid_in = 1'b0;
    check_eq("lat1_valid_out_pipe", {31'd0, valid_out}, 32'd0);
    check_eq("lat1_valid_out_nopipe", {31'd0, valid_out0}, 32'd1);
    check_eq("lat1_out_D_nopipe", {8'd0, out_D0}, 32'd7);
    check_eq("out_A", {24'd0, out_A}, 32'd5);
    tick();
    check_eq("noload_valid_out", {31'd0, valid_out}, 32'd1);
    check_eq("noload_out_D", {8'd0, out_D}, 32'd7);

    // Load 3, swap, then -4*3 + 100.
    wt_load = 1'b1; wt = 8'd3;
    tick();
    wt_load = 1'b0; wt_swap = 1'b1;
    check_eq("wt_out_chain", {24'd0, wt_out}, 32'd3);
    check_eq("wt_load_out_chain", {31'd0, wt_load_out}, 32'd1);
    tick();
    wt_swap = 1'b0; valid_in = 1'b1; in_A = 8'hFC; in_B = 24'd100;
    tick();
    valid_in = 1'b0;
    tick();
    check_eq("mac88_valid", {31'd0, valid_out}, 32'd1);
    check_eq("mac88_out_D", {8'd0, out_D}, 32'd88);
    tick();
    check_eq("hold_valid", {31'd0, valid_out}, 32'd0);
    check_eq("hold_out_D", {8'd0, out_D}, 32'd88);

    // Shadow empty: load 9 + swap together keeps active = 3.
    wt_load = 1'b1; wt = 8'd9; wt_swap = 1'b1;
    tick();
    idle(); valid_in = 1'b1; in_A = 8'd1; in_B = 24'd0;
    tick();
    valid_in = 1'b0;
    tick();
    check_eq("swap_ignored", {8'd0, out_D}, 32'd3);
    wt_swap = 1'b1;
    tick();
    wt_swap = 1'b0; valid_in = 1'b1; in_A = 8'd1; in_B = 24'd0;
    tick();
    valid_in = 1'b0;
    tick();
    check_eq("swap_later", {8'd0, out_D}, 32'd9);

    // Active 2, shadow 5; swap while a sample is in flight, back-to-back.
    wt_load = 1'b1; wt = 8'd2;
    tick();
    wt_load = 1'b0; wt_swap = 1'b1;
    tick();
    wt_swap = 1'b0; wt_load = 1'b1; wt = 8'd5;
    tick();
    wt_load = 1'b0; wt_swap = 1'b1; valid_in = 1'b1; in_A = 8'd10; in_B = 24'd0;
    tick();
    wt_swap = 1'b0;
    tick();
    valid_in = 1'b0;
    check_eq("b2b_first_valid", {31'd0, valid_out}, 32'd1);
    check_eq("b2b_first_out_D", {8'd0, out_D}, 32'd20);
    tick();
    check_eq("b2b_second_valid", {31'd0, valid_out}, 32'd1);
    check_eq("b2b_second_out_D", {8'd0, out_D}, 32'd50);
    tick();
    check_eq("b2b_drain_valid", {31'd0, valid_out}, 32'd0);

    // Weight 127 for overflow checks.
    wt_load = 1'b1; wt = 8'd127;
    tick();
    wt_load = 1'b0; wt_swap = 1'b1;
    tick();
    wt_swap = 1'b0; valid_in = 1'b1; in_A = 8'd127; in_B16 = 16'd32767; in_B = 24'd32767;
    tick();
    valid_in = 1'b0;
    tick();
    check_eq("sat_pos_out_D", {16'd0, out_D_s}, 32'd32767);
    check_eq("sat_pos_ovf", {31'd0, ovf_s}, 32'd1);
    check_eq("wrap_pos_out_D", {16'd0, out_D_w}, 32'h0000BF00);
    check_eq("wrap_pos_ovf", {31'd0, ovf_w}, 32'd1);
    check_eq("wide_no_ovf_out_D", {8'd0, out_D}, 32'd48896);
    check_eq("wide_no_ovf", {31'd0, ovf}, 32'd0);

    // -128*127 + -32768 below the 16-bit range.
    valid_in = 1'b1; in_A = 8'h80; in_B16 = 16'h8000; in_B = 24'hFF8000;
    tick();
    valid_in = 1'b0;
    tick();
    check_eq("sat_neg_out_D", {16'd0, out_D_s}, 32'h00008000);
    check_eq("wrap_neg_out_D", {16'd0, out_D_w}, 32'h00004080);
    check_eq("wide_neg_out_D", {8'd0, out_D}, 32'h00FF4080);

    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("clr_ovf_s", {31'd0, ovf_s}, 32'd0);
    check_eq("clr_ovf_w", {31'd0, ovf_w}, 32'd0);

    // Clear coincides with a new overflow reaching the output stage.
    valid_in = 1'b1; in_A = 8'd127; in_B16 = 16'd32767; in_B = 24'd0;
    tick();
    valid_in = 1'b0; clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check_eq("set_beats_clr_s", {31'd0, ovf_s}, 32'd1);
    check_eq("set_beats_clr_w", {31'd0, ovf_w}, 32'd1);

    // Reset with a result on the output and a sample in stage 1.
    valid_in = 1'b1; in_A = 8'd1; in_B = 24'd11; in_B16 = 16'd11;
    tick();
    tick();
    check_eq("pre_rst_valid", {31'd0, valid_out}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    check_eq("midrst_out_D", {8'd0, out_D}, 32'd0);
    check_eq("midrst_ovf_s", {31'd0, ovf_s}, 32'd0);
    check_eq("midrst_wt_out", {24'd0, wt_out}, 32'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_valid", {31'd0, valid_out}, 32'd0);
    valid_in = 1'b1; in_A = 8'd1; in_B = 24'd7;
    tick();
    valid_in = 1'b0;
    tick();
    check_eq("post_rst_out_D", {8'd0, out_D}, 32'd7);
    check_eq("post_rst_valid2", {31'd0, valid_out}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
